or1200_stall_gen: RTL

- Producer of the pipeline freeze vector (if/id/ex/wb_freeze) consumed by or1200_ctrl and the other pipeline stages.
- Turns ID-stage multicycle/wait_on decode, LSU/IF stalls, debug stall and flush into cycle-exact freezes.
- Owns the multicycle down-counter, the wait-on FSM and the flush-extension register.
- Sits between or1200_ctrl (decode source, freeze sink) and the LSU, IF, MAC, FPU, SPR and DU stall sources.

---
 rtl/or1200_stall_pkg.sv | 23 ++
 rtl/or1200_stall_mc_cnt.sv | 45 ++++
 rtl/or1200_stall_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/or1200_stall_pkg.sv
// rtl/or1200_stall_pkg.sv - shared types and defaults for the stall generator
// Purpose: wait_on encodings, wait FSM state type and default widths used by
//          or1200_stall_gen and or1200_stall_mc_cnt.
// Ports:   none (package).
package or1200_stall_pkg;

  localparam int MC_W_DEF  = 3;
  localparam int WO_W_DEF  = 2;
  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] WO_NONE    = 2'd0;
  localparam logic [1:0] WO_MULTMAC = 2'd1;
  localparam logic [1:0] WO_FPU     = 2'd2;
  localparam logic [1:0] WO_MTSPR   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_W_MAC   = 2'd1,
    ST_W_FPU   = 2'd2,
    ST_W_MTSPR = 2'd3
  } wait_state_t;

endpackage

// File: rtl/or1200_stall_mc_cnt.sv
// rtl/or1200_stall_mc_cnt.sv - multicycle down-counter holding EX after issue
// Purpose: loads the issuing insn's multicycle count, counts down to zero and
//          reports mc_busy while nonzero; flush clears it.
// Ports:   clk, rst (async active-low), issue, flush, load_val[MC_W] in;
//          mc_busy out.
module or1200_stall_mc_cnt
  import or1200_stall_pkg::*;
#(
  parameter int MC_W = MC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic            flush,
  input  logic [MC_W-1:0] load_val,
  output logic            mc_busy
);

  logic [MC_W-1:0] mc_cnt_q;
  logic [MC_W-1:0] mc_cnt_d;

  // The count keeps running even while WB is frozen: it measures EX latency,
  // not retirement.
  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (flush) begin
      mc_cnt_d = '0;
    end else if (issue) begin
      mc_cnt_d = load_val;
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - MC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc_cnt_q <= '0;
    end else begin
      mc_cnt_q <= mc_cnt_d;
    end
  end

  assign mc_busy = (mc_cnt_q != '0);

endmodule

// File: rtl/or1200_stall_gen.sv
// rtl/or1200_stall_gen.sv - pipeline freeze vector generator
// Purpose: combines LSU/IF/DU stalls, multicycle count, wait-on FSM and the
//          flush extension into monotone if/id/ex/wb freezes, and counts
//          ex_freeze cycles.
// Ports:   clk, rst (async active-low); id_multicycle, id_wait_on, id_void,
//          flushpipe, mac/fpu/mtspr_done, lsu_stall, if_stall,
//          force_dslot_fetch, du_stall, stall_cnt_clr in;
//          if/id/ex/wb_freeze, mc_busy, wait_busy, stall_cnt out.
module or1200_stall_gen
  import or1200_stall_pkg::*;
#(
  parameter int MC_W  = MC_W_DEF,
  parameter int WO_W  = WO_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MC_W-1:0]  id_multicycle,
  input  logic [WO_W-1:0]  id_wait_on,
  input  logic             id_void,
  input  logic             flushpipe,
  input  logic             mac_done,
  input  logic             fpu_done,
  input  logic             mtspr_done,
  input  logic             lsu_stall,
  input  logic             if_stall,
  input  logic             force_dslot_fetch,
  input  logic             du_stall,
  input  logic             stall_cnt_clr,
  output logic             if_freeze,
  output logic             id_freeze,
  output logic             ex_freeze,
  output logic             wb_freeze,
  output logic             mc_busy,
  output logic             wait_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  wait_state_t      state_q, state_d;
  logic             flush_ext_q, flush_ext_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             issue;

  assign wait_busy = (state_q != ST_IDLE);

  assign wb_freeze = lsu_stall | du_stall | (if_stall & force_dslot_fetch);
  assign ex_freeze = wb_freeze | mc_busy | wait_busy;
  assign id_freeze = ex_freeze | if_stall;
  // A fetch killed by flush still has to come back before IF may move.
  assign if_freeze = id_freeze | flush_ext_q;

  assign issue = !id_freeze & !id_void & !flushpipe;

  or1200_stall_mc_cnt #(
    .MC_W (MC_W)
  ) u_mc_cnt (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .flush    (flushpipe),
    .load_val (id_multicycle),
    .mc_busy  (mc_busy)
  );

  // Dones are only looked at in the matching wait state, so a done asserted
  // in the issue cycle or belonging to another unit has no effect.
  always_comb begin
    state_d = state_q;
    if (flushpipe) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            if (id_wait_on == WO_W'(WO_MULTMAC))      state_d = ST_W_MAC;
            else if (id_wait_on == WO_W'(WO_FPU))     state_d = ST_W_FPU;
            else if (id_wait_on == WO_W'(WO_MTSPR))   state_d = ST_W_MTSPR;
            else                                      state_d = ST_IDLE;
          end
        end
        ST_W_MAC:   if (mac_done)   state_d = ST_IDLE;
        ST_W_FPU:   if (fpu_done)   state_d = ST_IDLE;
        ST_W_MTSPR: if (mtspr_done) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    flush_ext_d = flush_ext_q;
    if (!if_stall) begin
      flush_ext_d = 1'b0;
    end else if (flushpipe) begin
      flush_ext_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (ex_freeze && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      flush_ext_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_ext_q <= flush_ext_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
